// File: rtl/kf8237_address_latch_page_if.sv
// Bus bundle for the KF8237 page-register / address-latch block.
// The master drives the CPU and DMA-controller side; the slave is the latch block.
interface kf8237_address_latch_page_if;
  logic [7:0]  internal_data_bus;
  logic [3:0]  write_page_register;
  logic [3:0]  read_page_register;
  logic [7:0]  read_page_data;
  logic [3:0]  transfer_register_select;
  logic [15:0] transfer_address;
  logic        update_high_address;
  logic        cycle_start;
  logic        cycle_end;
  logic        address_enable;
  logic        address_strobe;
  logic [23:0] output_address;

  modport master (
    output internal_data_bus, write_page_register, read_page_register,
           transfer_register_select, transfer_address, update_high_address,
           cycle_start, cycle_end,
    input  read_page_data, address_enable, address_strobe, output_address
  );

  modport slave (
    input  internal_data_bus, write_page_register, read_page_register,
           transfer_register_select, transfer_address, update_high_address,
           cycle_start, cycle_end,
    output read_page_data, address_enable, address_strobe, output_address
  );
endinterface

// File: rtl/kf8237_address_latch_page.sv
// KF8237 page registers plus the AEN/ADSTB sequencer that forms the 24-bit DMA address.
// High address byte is re-strobed only when it changes or the active channel changes.
module kf8237_address_latch_page (
  input  logic                              clock,
  input  logic                              reset_n,
  kf8237_address_latch_page_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, STROBE, DRIVE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q [4];
  logic [7:0]  page_d [4];
  logic [7:0]  latched_page_q, latched_page_d;
  logic [7:0]  high_latch_q, high_latch_d;
  logic        high_valid_q, high_valid_d;
  logic [1:0]  latched_channel_q, latched_channel_d;
  logic        end_pending_q, end_pending_d;
  logic        address_enable_q, address_enable_d;
  logic        address_strobe_q, address_strobe_d;
  logic [23:0] output_address_q, output_address_d;

  logic [1:0]  active_channel;
  logic        need_strobe;
  logic [7:0]  read_data;

  always_comb begin
    active_channel = 2'd0;
    if (bus.transfer_register_select[0])      active_channel = 2'd0;
    else if (bus.transfer_register_select[1]) active_channel = 2'd1;
    else if (bus.transfer_register_select[2]) active_channel = 2'd2;
    else if (bus.transfer_register_select[3]) active_channel = 2'd3;
  end

  always_comb begin
    read_data = 8'h00;
    if (bus.read_page_register[0])      read_data = page_q[0];
    else if (bus.read_page_register[1]) read_data = page_q[1];
    else if (bus.read_page_register[2]) read_data = page_q[2];
    else if (bus.read_page_register[3]) read_data = page_q[3];
  end

  assign need_strobe = !high_valid_q || bus.update_high_address ||
                       (active_channel != latched_channel_q);

  always_comb begin
    state_d           = state_q;
    latched_page_d    = latched_page_q;
    high_latch_d      = high_latch_q;
    high_valid_d      = high_valid_q;
    latched_channel_d = latched_channel_q;
    end_pending_d     = end_pending_q;
    for (int i = 0; i < 4; i++) begin
      page_d[i] = bus.write_page_register[i] ? bus.internal_data_bus : page_q[i];
    end

    case (state_q)
      IDLE: begin
        if (bus.cycle_start) begin
          latched_page_d    = page_q[active_channel];
          latched_channel_d = active_channel;
          state_d           = need_strobe ? STROBE : DRIVE;
        end
      end
      STROBE: begin
        high_latch_d = bus.transfer_address[15:8];
        high_valid_d = 1'b1;
        state_d      = DRIVE;
        if (bus.cycle_end) end_pending_d = 1'b1;
      end
      DRIVE: begin
        // A new start always wins over an end (burst continues without IDLE).
        if (bus.cycle_start) begin
          latched_page_d    = page_q[active_channel];
          latched_channel_d = active_channel;
          end_pending_d     = 1'b0;
          state_d           = need_strobe ? STROBE : DRIVE;
        end else if (bus.cycle_end || end_pending_q) begin
          high_valid_d  = 1'b0;
          end_pending_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they appear one clock after the request.
    address_enable_d = 1'b0;
    address_strobe_d = 1'b0;
    output_address_d = 24'h0;
    case (state_d)
      STROBE: begin
        address_enable_d = 1'b1;
        address_strobe_d = 1'b1;
        output_address_d = {latched_page_d, bus.transfer_address};
      end
      DRIVE: begin
        address_enable_d = 1'b1;
        output_address_d = {latched_page_d, high_latch_d, bus.transfer_address[7:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      for (int i = 0; i < 4; i++) page_q[i] <= 8'h00;
      latched_page_q    <= 8'h00;
      high_latch_q      <= 8'h00;
      high_valid_q      <= 1'b0;
      latched_channel_q <= 2'd0;
      end_pending_q     <= 1'b0;
      address_enable_q  <= 1'b0;
      address_strobe_q  <= 1'b0;
      output_address_q  <= 24'h0;
    end else begin
      state_q           <= state_d;
      for (int i = 0; i < 4; i++) page_q[i] <= page_d[i];
      latched_page_q    <= latched_page_d;
      high_latch_q      <= high_latch_d;
      high_valid_q      <= high_valid_d;
      latched_channel_q <= latched_channel_d;
      end_pending_q     <= end_pending_d;
      address_enable_q  <= address_enable_d;
      address_strobe_q  <= address_strobe_d;
      output_address_q  <= output_address_d;
    end
  end

  assign bus.read_page_data = read_data;
  assign bus.address_enable = address_enable_q;
  assign bus.address_strobe = address_strobe_q;
  assign bus.output_address = output_address_q;

endmodule

// File: tb/tb_kf8237_address_latch_page.sv
// Self-checking bench for kf8237_address_latch_page: page register table plus
// a scoreboard of per-cycle AEN/ADSTB/address expectations.
module tb_kf8237_address_latch_page;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  kf8237_address_latch_page_if bus ();

  kf8237_address_latch_page dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] wr;
    logic [7:0] data;
    logic [3:0] rd;
    logic [7:0] exp_rd;
  } page_vec_t;

  typedef struct {
    string       name;
    logic        aen;
    logic        stb;
    logic [23:0] addr;
  } expect_t;

  expect_t   exp_q[$];
  page_vec_t page_vec [10];
  int        checks = 0;
  int        passes = 0;

  task automatic apply_stimulus(input string name, input logic cs, input logic ce,
                                input logic [3:0] sel, input logic [15:0] ta,
                                input logic upd, input logic [3:0] wr,
                                input logic [7:0] data, input logic aen,
                                input logic stb, input logic [23:0] addr);
    expect_t e;
    bus.cycle_start              = cs;
    bus.cycle_end                = ce;
    bus.transfer_register_select = sel;
    bus.transfer_address         = ta;
    bus.update_high_address      = upd;
    bus.write_page_register      = wr;
    bus.internal_data_bus        = data;
    e.name = name;
    e.aen  = aen;
    e.stb  = stb;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  task automatic check_output();
    expect_t e;
    logic [25:0] got, want;
    @(posedge clock);
    #1;
    e    = exp_q.pop_front();
    got  = {bus.address_enable, bus.address_strobe, bus.output_address};
    want = {e.aen, e.stb, e.addr};
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s: aen/stb/addr got %b/%b/%h, expected %b/%b/%h",
                  e.name, got[25], got[24], got[23:0], want[25], want[24], want[23:0]);
  endtask

  task automatic check_read(input string name, input logic [3:0] rd, input logic [7:0] exp_rd);
    bus.read_page_register = rd;
    #1;
    checks++;
    if (bus.read_page_data === exp_rd) passes++;
    else $display("[TB] FAIL %s: read_page_data got %h, expected %h",
                  name, bus.read_page_data, exp_rd);
  endtask

  task automatic cyc(input string name, input logic cs, input logic ce,
                     input logic [3:0] sel, input logic [15:0] ta, input logic upd,
                     input logic aen, input logic stb, input logic [23:0] addr);
    apply_stimulus(name, cs, ce, sel, ta, upd, 4'b0000, 8'h00, aen, stb, addr);
    check_output();
  endtask

  initial begin
    page_vec[0] = '{4'b0001, 8'h11, 4'b0001, 8'h11};
    page_vec[1] = '{4'b0010, 8'h22, 4'b0010, 8'h22};
    page_vec[2] = '{4'b1000, 8'h44, 4'b1000, 8'h44};
    page_vec[3] = '{4'b0100, 8'h0A, 4'b0100, 8'h0A};
    page_vec[4] = '{4'b1001, 8'h99, 4'b1000, 8'h99};
    page_vec[5] = '{4'b0000, 8'hFF, 4'b0001, 8'h99};
    page_vec[6] = '{4'b0000, 8'h00, 4'b0110, 8'h22};
    page_vec[7] = '{4'b0000, 8'h00, 4'b0000, 8'h00};
    page_vec[8] = '{4'b0000, 8'h00, 4'b1100, 8'h0A};
    page_vec[9] = '{4'b0000, 8'h00, 4'b1111, 8'h99};

    bus.read_page_register = 4'b0000;
    reset_n = 1'b0;
    apply_stimulus("reset_idle", 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0, 4'b0000, 8'h00,
                   1'b0, 1'b0, 24'h0);
    check_output();
    check_read("reset_page0", 4'b0001, 8'h00);
    reset_n = 1'b1;

    // Page register write/read table; IDLE outputs must stay quiet throughout.
    for (int i = 0; i < 10; i++) begin
      apply_stimulus($sformatf("page_idle_%0d", i), 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0,
                     page_vec[i].wr, page_vec[i].data, 1'b0, 1'b0, 24'h0);
      check_output();
      bus.write_page_register = 4'b0000;
      check_read($sformatf("page_rd_%0d", i), page_vec[i].rd, page_vec[i].exp_rd);
    end

    cyc("start_strobe",   1, 0, 4'b0100, 16'h1234, 0, 1, 1, 24'h0A1234);
    cyc("first_drive",    0, 0, 4'b0100, 16'h1234, 0, 1, 0, 24'h0A1234);
    cyc("burst_nostrobe", 1, 0, 4'b0100, 16'h1235, 0, 1, 0, 24'h0A1235);
    cyc("burst_upd_high", 1, 0, 4'b0100, 16'h1300, 1, 1, 1, 24'h0A1300);
    cyc("drive_1300",     0, 0, 4'b0100, 16'h1300, 0, 1, 0, 24'h0A1300);
    cyc("end_to_idle",    0, 1, 4'b0100, 16'h1300, 0, 0, 0, 24'h0);
    cyc("end_in_idle",    0, 1, 4'b0100, 16'h1300, 0, 0, 0, 24'h0);
    cyc("restrobe_after", 1, 0, 4'b0100, 16'h1300, 0, 1, 1, 24'h0A1300);

    apply_stimulus("write_in_drive", 1'b0, 1'b0, 4'b0100, 16'h1300, 1'b0, 4'b0100, 8'h55,
                   1'b1, 1'b0, 24'h0A1300);
    check_output();
    check_read("page2_readback", 4'b0100, 8'h55);
    cyc("page_held",      0, 0, 4'b0100, 16'h1300, 0, 1, 0, 24'h0A1300);
    cyc("page_recapture", 1, 0, 4'b0100, 16'h1301, 0, 1, 0, 24'h551301);

    cyc("chan_switch",    1, 0, 4'b0010, 16'h1302, 0, 1, 1, 24'h221302);
    cyc("strobe_ignores", 1, 1, 4'b0010, 16'h1302, 0, 1, 0, 24'h221302);
    cyc("deferred_end",   0, 0, 4'b0010, 16'h1302, 0, 0, 0, 24'h0);

    cyc("wrap_strobe",    1, 0, 4'b0000, 16'hFFFF, 0, 1, 1, 24'h99FFFF);
    cyc("wrap_drive",     0, 0, 4'b0000, 16'hFFFF, 0, 1, 0, 24'h99FFFF);
    cyc("wrap_to_zero",   0, 0, 4'b0000, 16'h0000, 0, 1, 0, 24'h99FF00);
    cyc("start_and_end",  1, 1, 4'b0000, 16'h0000, 1, 1, 1, 24'h990000);

    reset_n = 1'b0;
    cyc("reset_in_strobe", 0, 0, 4'b0000, 16'h0000, 0, 0, 0, 24'h0);
    for (int i = 0; i < 4; i++) begin
      check_read($sformatf("reset_page%0d", i), 4'(1 << i), 8'h00);
    end
    reset_n = 1'b1;
    cyc("idle_after_reset", 0, 0, 4'b0000, 16'h0000, 0, 0, 0, 24'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
